// File: rtl/add_acc.sv
// Per-lane signed accumulator for MUL product lanes. It sums num_reads_per_iter
// products into one result per iteration, for num_iters iterations per run.
module add_acc #(
  parameter int NUM_INPUTS             = 8,
  parameter int DATA_WIDTH             = 8,
  parameter int ACC_WIDTH              = 32,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                configure,
  input  logic [LOG_MAX_ITERS-1:0]            num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]   num_reads_per_iter,
  input  logic [2*NUM_INPUTS*DATA_WIDTH-1:0]  data_in,
  input  logic                                valid_in,
  output logic                                avail_out,
  output logic [NUM_INPUTS*ACC_WIDTH-1:0]     data_out,
  output logic                                valid_out,
  input  logic                                avail_in
);

  // state   | meaning
  // IDLE    | unconfigured or run complete; no input, no output
  // ACC     | accepting products into the lane accumulators
  // OUT     | presenting a finished result until downstream takes it
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam int PW = 2 * DATA_WIDTH;

  logic [1:0]                             r_state;
  logic [LOG_MAX_ITERS-1:0]               r_iters_cfg;
  logic [LOG_MAX_ITERS-1:0]               r_iter_cnt;
  logic [LOG_MAX_READS_PER_ITER-1:0]      r_reads_cfg;
  logic [LOG_MAX_READS_PER_ITER-1:0]      r_read_cnt;
  logic [NUM_INPUTS-1:0][ACC_WIDTH-1:0]   r_acc;
  logic [NUM_INPUTS-1:0][ACC_WIDTH-1:0]   r_dout;

  logic [NUM_INPUTS-1:0][ACC_WIDTH-1:0]   w_sum;
  logic [LOG_MAX_READS_PER_ITER-1:0]      w_read_cnt_nxt;
  logic [LOG_MAX_ITERS-1:0]               w_iter_cnt_nxt;
  logic                                   w_accept;
  logic                                   w_last_read;
  logic                                   w_out_xfer;
  logic                                   w_more_iters;
  logic                                   w_first_read;
  logic                                   w_cfg_zero;

  function automatic logic [ACC_WIDTH-1:0] sext(input logic [PW-1:0] p);
    return ACC_WIDTH'($signed(p));
  endfunction

  assign avail_out = (r_state == ST_ACC);
  assign valid_out = (r_state == ST_OUT);
  assign data_out  = r_dout;

  assign w_accept       = valid_in && (r_state == ST_ACC);
  assign w_out_xfer     = avail_in && (r_state == ST_OUT);
  assign w_read_cnt_nxt = r_read_cnt + LOG_MAX_READS_PER_ITER'(1);
  assign w_iter_cnt_nxt = r_iter_cnt + LOG_MAX_ITERS'(1);
  assign w_last_read    = (w_read_cnt_nxt == r_reads_cfg);
  assign w_more_iters   = (w_iter_cnt_nxt < r_iters_cfg);
  assign w_first_read   = (r_read_cnt == '0);
  assign w_cfg_zero     = (num_iters == '0) || (num_reads_per_iter == '0);

  // First product of an iteration overwrites, so no explicit clear is needed.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_first_read) begin
        w_sum[i] = sext(data_in[i*PW +: PW]);
      end else begin
        w_sum[i] = r_acc[i] + sext(data_in[i*PW +: PW]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_iters_cfg <= '0;
      r_iter_cnt  <= '0;
      r_reads_cfg <= '0;
      r_read_cnt  <= '0;
      r_acc       <= '0;
      r_dout      <= '0;
    end else if (configure) begin
      r_iters_cfg <= num_iters;
      r_reads_cfg <= num_reads_per_iter;
      r_iter_cnt  <= '0;
      r_read_cnt  <= '0;
      r_state     <= w_cfg_zero ? ST_IDLE : ST_ACC;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_acc <= w_sum;
            if (w_last_read) begin
              r_dout     <= w_sum;
              r_read_cnt <= '0;
              r_state    <= ST_OUT;
            end else begin
              r_read_cnt <= w_read_cnt_nxt;
            end
          end
        end
        ST_OUT: begin
          if (w_out_xfer) begin
            r_iter_cnt <= w_iter_cnt_nxt;
            r_state    <= w_more_iters ? ST_ACC : ST_IDLE;
          end
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_acc.sv
// Directed bench for add_acc: default-width instance for most scenarios plus a
// 16-bit accumulator instance for the wrap-around case.
module tb_add_acc;

  logic         clk;
  logic         rst;
  logic         configure;
  logic [15:0]  num_iters;
  logic [15:0]  num_reads_per_iter;
  logic [127:0] data_in;
  logic         valid_in;
  logic         avail_out;
  logic [255:0] data_out;
  logic         valid_out;
  logic         avail_in;

  logic         w_configure;
  logic [15:0]  w_num_iters;
  logic [15:0]  w_num_reads;
  logic [127:0] w_data_in;
  logic         w_valid_in;
  logic         w_avail_out;
  logic [127:0] w_data_out;
  logic         w_valid_out;
  logic         w_avail_in;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] basic_vec [3];

  add_acc u_dut (
    .clk                (clk),
    .rst                (rst),
    .configure          (configure),
    .num_iters          (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .data_in            (data_in),
    .valid_in           (valid_in),
    .avail_out          (avail_out),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .avail_in           (avail_in)
  );

  add_acc #(.ACC_WIDTH(16)) u_dut_w (
    .clk                (clk),
    .rst                (rst),
    .configure          (w_configure),
    .num_iters          (w_num_iters),
    .num_reads_per_iter (w_num_reads),
    .data_in            (w_data_in),
    .valid_in           (w_valid_in),
    .avail_out          (w_avail_out),
    .data_out           (w_data_out),
    .valid_out          (w_valid_out),
    .avail_in           (w_avail_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane(input int i);
    return data_out[i*32 +: 32];
  endfunction

  task automatic set_lane0(input logic [15:0] v);
    data_in       = '0;
    data_in[15:0] = v;
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 8; i++) data_in[i*16 +: 16] = v;
  endtask

  task automatic do_cfg(input logic [15:0] it, input logic [15:0] rd);
    configure          = 1'b1;
    num_iters          = it;
    num_reads_per_iter = rd;
    tick();
    configure          = 1'b0;
  endtask

  initial begin
    basic_vec = '{16'h0001, 16'h0002, 16'h0003};
    rst = 1'b1; configure = 1'b0; num_iters = '0; num_reads_per_iter = '0;
    data_in = '0; valid_in = 1'b0; avail_in = 1'b0;
    w_configure = 1'b0; w_num_iters = '0; w_num_reads = '0;
    w_data_in = '0; w_valid_in = 1'b0; w_avail_in = 1'b0;
    tick();
    tick();
    check("rst_valid_out", 64'(valid_out), 64'h0);
    check("rst_avail_out", 64'(avail_out), 64'h0);
    check("rst_data_out", 64'(|data_out), 64'h0);
    rst = 1'b0;

    // Idle ignores valid_in until configured
    valid_in = 1'b1;
    set_all(16'h0011);
    repeat (3) tick();
    check("idle_hold_avail", 64'(avail_out), 64'h0);
    check("idle_hold_valid", 64'(valid_out), 64'h0);
    valid_in = 1'b0;

    // Basic: 2 iterations of 3 reads
    do_cfg(16'd2, 16'd3);
    check("cfg_avail", 64'(avail_out), 64'h1);
    for (int k = 0; k < 3; k++) begin
      set_lane0(basic_vec[k]);
      valid_in = 1'b1;
      tick();
      if (k < 2) check("basic_early_valid", 64'(valid_out), 64'h0);
    end
    valid_in = 1'b0;
    check("basic1_valid", 64'(valid_out), 64'h1);
    check("basic1_lane0", 64'(lane(0)), 64'h6);
    check("basic1_lane1", 64'(lane(1)), 64'h0);
    check("basic1_avail", 64'(avail_out), 64'h0);
    avail_in = 1'b1;
    tick();
    avail_in = 1'b0;
    check("basic_back_acc", 64'(avail_out), 64'h1);
    check("basic_back_valid", 64'(valid_out), 64'h0);
    check("basic_hold_dout", 64'(lane(0)), 64'h6);
    for (int k = 0; k < 3; k++) begin
      set_lane0(16'hFFFF);
      valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    check("basic2_valid", 64'(valid_out), 64'h1);
    check("basic2_lane0", 64'(lane(0)), 64'hFFFF_FFFD);
    avail_in = 1'b1;
    tick();
    avail_in = 1'b0;
    check("basic_end_avail", 64'(avail_out), 64'h0);
    check("basic_end_valid", 64'(valid_out), 64'h0);
    check("basic_end_dout", 64'(lane(0)), 64'hFFFF_FFFD);

    // Single read per iteration passes the sign-extended product through
    do_cfg(16'd2, 16'd1);
    set_lane0(16'h8000);
    data_in[3*16 +: 16] = 16'h00FF;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("pass1_valid", 64'(valid_out), 64'h1);
    check("pass1_lane0", 64'(lane(0)), 64'hFFFF_8000);
    check("pass1_lane3", 64'(lane(3)), 64'h0000_00FF);
    avail_in = 1'b1;
    tick();
    check("pass_back_acc", 64'(avail_out), 64'h1);
    set_lane0(16'h0005);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("pass2_lane0", 64'(lane(0)), 64'h5);
    check("pass2_lane3", 64'(lane(3)), 64'h0);
    tick();
    avail_in = 1'b0;
    check("pass_end_avail", 64'(avail_out), 64'h0);

    // Backpressure: result held while avail_in=0, inputs refused
    do_cfg(16'd2, 16'd2);
    valid_in = 1'b1;
    set_lane0(16'h0005);
    tick();
    set_lane0(16'h0007);
    tick();
    set_lane0(16'h0100);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 64'(valid_out), 64'h1);
      check("bp_lane0", 64'(lane(0)), 64'hC);
      check("bp_avail", 64'(avail_out), 64'h0);
      tick();
    end
    valid_in = 1'b0;
    avail_in = 1'b1;
    tick();
    avail_in = 1'b0;
    check("bp_release_avail", 64'(avail_out), 64'h1);
    check("bp_release_valid", 64'(valid_out), 64'h0);

    // Gaps: valid_in toggles, only handshakes count
    do_cfg(16'd1, 16'd4);
    for (int c = 0; c < 7; c++) begin
      valid_in = (c % 2 == 0);
      if (c % 2 == 0) set_all(16'h0010);
      else set_all(16'h1234);
      tick();
      if (c == 5) check("gaps_early_valid", 64'(valid_out), 64'h0);
    end
    valid_in = 1'b0;
    check("gaps_valid", 64'(valid_out), 64'h1);
    for (int i = 0; i < 8; i++) check("gaps_lane", 64'(lane(i)), 64'h40);
    avail_in = 1'b1;
    tick();
    avail_in = 1'b0;
    check("gaps_end_avail", 64'(avail_out), 64'h0);

    // Zero configuration stays idle
    valid_in = 1'b1;
    set_all(16'h0001);
    do_cfg(16'd0, 16'd5);
    for (int c = 0; c < 3; c++) begin
      check("zero_iters_avail", 64'(avail_out), 64'h0);
      check("zero_iters_valid", 64'(valid_out), 64'h0);
      tick();
    end
    do_cfg(16'd3, 16'd0);
    for (int c = 0; c < 3; c++) begin
      check("zero_reads_avail", 64'(avail_out), 64'h0);
      check("zero_reads_valid", 64'(valid_out), 64'h0);
      tick();
    end
    valid_in = 1'b0;

    // Reset wins over configure, and clears data_out
    rst = 1'b1;
    do_cfg(16'd1, 16'd1);
    rst = 1'b0;
    check("rstpri_avail", 64'(avail_out), 64'h0);
    check("rstpri_valid", 64'(valid_out), 64'h0);
    check("rstpri_dout", 64'(lane(0)), 64'h0);

    // Mid-run reset, then mid-run reconfigure
    do_cfg(16'd1, 16'd3);
    valid_in = 1'b1;
    set_lane0(16'd100);
    tick();
    set_lane0(16'd200);
    tick();
    valid_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_avail", 64'(avail_out), 64'h0);
    check("mid_rst_valid", 64'(valid_out), 64'h0);
    check("mid_rst_dout", 64'(lane(0)), 64'h0);
    do_cfg(16'd1, 16'd2);
    valid_in = 1'b1;
    set_lane0(16'd50);
    tick();
    set_lane0(16'h03E7);
    do_cfg(16'd1, 16'd2);
    set_lane0(16'd3);
    tick();
    check("mid_cfg_early_valid", 64'(valid_out), 64'h0);
    set_lane0(16'd4);
    tick();
    valid_in = 1'b0;
    check("mid_cfg_valid", 64'(valid_out), 64'h1);
    check("mid_cfg_lane0", 64'(lane(0)), 64'h7);
    avail_in = 1'b1;
    tick();
    avail_in = 1'b0;

    // Wrap-around on 16-bit accumulators
    w_configure = 1'b1;
    w_num_iters = 16'd1;
    w_num_reads = 16'd2;
    tick();
    w_configure = 1'b0;
    w_valid_in = 1'b1;
    w_data_in = '0;
    w_data_in[15:0] = 16'h7FFF;
    tick();
    w_data_in[15:0] = 16'h0001;
    tick();
    w_valid_in = 1'b0;
    check("wrap_valid", 64'(w_valid_out), 64'h1);
    check("wrap_lane0", 64'(w_data_out[15:0]), 64'h8000);
    check("wrap_other_lanes", 64'(|w_data_out[127:16]), 64'h0);
    check("wrap_avail", 64'(w_avail_out), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
